// File: rtl/fft_quad_capture_pkg.sv
// fft_quad_capture_pkg: shared constants and FSM state type for the fft_quad capture/replay sink
package fft_quad_pkg;
  localparam int DEF_LOG2_LEN = 14;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_K_W = 14;
  localparam int LANES = 4;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
endpackage

// File: rtl/fft_quad_capture_if.sv
// fft_quad_capture_if: fft_quad lane stream (no backpressure) and 64-bit AXI-Stream bundles
//   fft_quad_if : data_0..3, k, valid   (master drives, slave receives)
//   axis_if     : tdata, tuser, tvalid, tlast from master; tready from slave
interface fft_quad_if #(parameter int DATA_W = 64, parameter int K_W = 14);
  logic [DATA_W-1:0] data_0, data_1, data_2, data_3;
  logic [K_W-1:0] k;
  logic valid;
  modport master (output data_0, data_1, data_2, data_3, k, valid);
  modport slave (input data_0, data_1, data_2, data_3, k, valid);
endinterface

interface axis_if #(parameter int DATA_W = 64, parameter int K_W = 14);
  logic [DATA_W-1:0] tdata;
  logic [K_W-1:0] tuser;
  logic tvalid, tready, tlast;
  modport master (output tdata, tuser, tvalid, tlast, input tready);
  modport slave (input tdata, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/fft_quad_capture_ram.sv
// capture_ram: inferred simple dual-port RAM with a registered one-cycle read
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
module capture_ram #(
  parameter int W = 270,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_quad_capture.sv
// fft_quad_capture: captures one fft_quad frame into RAM, then replays it as a lane-ordered AXI-Stream
//   clk, resetn (async, active-low), arm : start capture from IDLE
//   s    : fft_quad lanes + bin index, no backpressure
//   m    : AXI-Stream out, tuser = bin index, tlast on the final word
//   busy : CAPTURE or DRAIN; done : last-word handshake; overflow : sticky dropped-beat flag
module fft_quad_capture
  import fft_quad_pkg::*;
#(
  parameter int LOG2_LEN = DEF_LOG2_LEN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int K_W = DEF_K_W
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        arm,
  fft_quad_if.slave   s,
  axis_if.master      m,
  output logic        busy,
  output logic        done,
  output logic        overflow
);
  localparam int BEAT_W = LANES * DATA_W + K_W;
  state_t state_q, state_d;
  logic [LOG2_LEN-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d;
  logic [1:0] lane_sel_q, lane_sel_d, occ;
  logic fetch_done_q, fetch_done_d, pend_q, pend_d, ovalid_q, ovalid_d, nvalid_q, nvalid_d;
  logic overflow_q, overflow_d;
  logic [BEAT_W-1:0] obeat_q, obeat_d, nbeat_q, nbeat_d, rdata;
  logic we, re, hs, last_word, free_out, is_last;
  capture_ram #(.W(BEAT_W), .AW(LOG2_LEN)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata ({s.k, s.data_3, s.data_2, s.data_1, s.data_0}),
    .re    (re),
    .raddr (fetch_ptr_q),
    .rdata (rdata)
  );
  assign is_last = lane_sel_q == 2'd3 && &rd_ptr_q;
  assign hs = ovalid_q && m.tready;
  assign last_word = hs && lane_sel_q == 2'd3;
  assign free_out = !ovalid_q || last_word;
  assign we = state_q == CAPTURE && s.valid;
  // Beats held or in flight; a read is issued only when both the output and
  // skid registers are guaranteed a free slot when its data returns.
  assign occ = 2'(ovalid_q) + 2'(nvalid_q) + 2'(pend_q);
  assign re = state_q == DRAIN && !fetch_done_q && occ < 2'd2;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fetch_ptr_d = fetch_ptr_q;
    fetch_done_d = fetch_done_q;
    lane_sel_d = lane_sel_q;
    overflow_d = overflow_q;
    ovalid_d = ovalid_q;
    nvalid_d = nvalid_q;
    obeat_d = obeat_q;
    nbeat_d = nbeat_q;
    pend_d = re;
    if (state_q == IDLE && arm) begin
      state_d = CAPTURE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fetch_ptr_d = '0;
      fetch_done_d = 1'b0;
      lane_sel_d = '0;
      overflow_d = 1'b0;
    end else if (s.valid && state_q != CAPTURE) overflow_d = 1'b1;
    if (we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      state_d = &wr_ptr_q ? DRAIN : state_q;
    end
    if (re) begin
      fetch_ptr_d = fetch_ptr_q + 1'b1;
      fetch_done_d = &fetch_ptr_q;
    end
    if (hs) begin
      lane_sel_d = lane_sel_q + 2'd1;
      rd_ptr_d = last_word ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end
    // Returning RAM data goes to the output register when it frees up,
    // otherwise it waits in the skid register.
    if (free_out) begin
      ovalid_d = nvalid_q || pend_q;
      obeat_d = nvalid_q ? nbeat_q : pend_q ? rdata : obeat_q;
      nvalid_d = nvalid_q && pend_q;
      nbeat_d = nvalid_q && pend_q ? rdata : nbeat_q;
    end else if (pend_q) begin
      nvalid_d = 1'b1;
      nbeat_d = rdata;
    end
    if (hs && is_last) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fetch_ptr_q <= '0;
      fetch_done_q <= 1'b0;
      lane_sel_q <= '0;
      overflow_q <= 1'b0;
      ovalid_q <= 1'b0;
      nvalid_q <= 1'b0;
      pend_q <= 1'b0;
      obeat_q <= '0;
      nbeat_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      fetch_done_q <= fetch_done_d;
      lane_sel_q <= lane_sel_d;
      overflow_q <= overflow_d;
      ovalid_q <= ovalid_d;
      nvalid_q <= nvalid_d;
      pend_q <= pend_d;
      obeat_q <= obeat_d;
      nbeat_q <= nbeat_d;
    end
  end
  assign m.tvalid = ovalid_q;
  assign m.tdata = obeat_q[DATA_W*int'(lane_sel_q) +: DATA_W];
  assign m.tuser = obeat_q[BEAT_W-1 -: K_W];
  assign m.tlast = ovalid_q && is_last;
  assign done = hs && is_last;
  assign busy = state_q != IDLE;
  assign overflow = overflow_q;
endmodule
